// File: rtl/debug_trace_port.sv
`timescale 1ns/1ps
// debug_trace_port
//   Bus-accessible trace FIFO that drains onto a parallel debug port. Software
//   pushes words through the DATA register. A small drain engine shows each
//   entry on debugport for at least hold+1 cycles and pulses debugport_stb
//   once for every new value.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-low reset
//   data_req       bus request; address/control held until granted
//   data_we        1 = write, 0 = read
//   data_be[3:0]   byte enables
//   data_addr      byte address, only [3:2] decoded
//                  (0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC unmapped)
//   data_wdata     write data
//   data_gnt       registered grant, never high two cycles in a row
//   data_rvalid    registered response valid, one cycle after the access
//   data_rdata     read data, valid with data_rvalid
//   data_err       error response, valid with data_rvalid
//   debugport      current trace value
//   debugport_stb  one-cycle pulse marking a new debugport value
module debug_trace_port #(
    parameter int PORT_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,
    output logic              data_err,
    output logic [PORT_W-1:0] debugport,
    output logic              debugport_stb
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;

    // Registered bus outputs
    logic              gnt_r;
    logic              rvalid_r;
    logic [31:0]       rdata_r;
    logic              err_r;

    // Trace FIFO
    logic [PORT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     cnt_r;

    // Control / status registers
    logic              ovf_r;
    logic [15:0]       hold_r;
    logic              enable_r;

    // Drain engine
    logic [0:0]        state_r;
    logic [15:0]       hcnt_r;
    logic [PORT_W-1:0] debug_r;
    logic              stb_r;

    // Combinational decode
    logic              access_s;
    logic              wr_s;
    logic [1:0]        sel_s;
    logic              empty_s;
    logic              full_s;
    logic              push_req_s;
    logic              push_s;
    logic              ovf_set_s;
    logic              ovf_clr_s;
    logic              ctrl_wr_s;
    logic              flush_s;
    logic              pop_ok_s;
    logic              pop_s;
    logic [31:0]       status_s;
    logic [31:0]       ctrl_s;
    logic [31:0]       rdata_s;
    logic              err_s;
    logic              unused_s;

    assign access_s   = data_req & gnt_r;
    assign wr_s       = access_s & data_we;
    assign sel_s      = data_addr[3:2];
    assign empty_s    = (cnt_r == {CW{1'b0}});
    assign full_s     = (cnt_r == CNT_FULL);
    assign push_req_s = wr_s & (sel_s == SEL_DATA) & data_be[0];
    // Fullness is judged on the count before this cycle, so a pop in the
    // same cycle never makes room for the incoming word.
    assign push_s     = push_req_s & ~full_s;
    assign ovf_set_s  = push_req_s & full_s;
    assign ovf_clr_s  = wr_s & (sel_s == SEL_STATUS) & data_be[0] & data_wdata[2];
    assign ctrl_wr_s  = wr_s & (sel_s == SEL_CTRL);
    assign flush_s    = ctrl_wr_s & data_be[2] & data_wdata[17];
    assign pop_ok_s   = ~empty_s & enable_r & ~flush_s;
    // A pop only happens when the engine is ready for a new entry.
    assign pop_s      = pop_ok_s & ((state_r == ST_IDLE) | (hcnt_r == 16'd0));

    // Address bits above [3:2] and byte lane 3 carry no function.
    assign unused_s   = ^{data_addr[31:4], data_addr[1:0], data_wdata, data_be[3]};

    assign data_gnt      = gnt_r;
    assign data_rvalid   = rvalid_r;
    assign data_rdata    = rdata_r;
    assign data_err      = err_r;
    assign debugport     = debug_r;
    assign debugport_stb = stb_r;

    // STATUS and CTRL read images
    always_comb begin
        status_s          = 32'd0;
        status_s[0]       = empty_s;
        status_s[1]       = full_s;
        status_s[2]       = ovf_r;
        status_s[3]       = (state_r == ST_ACTIVE);
        status_s[8 +: CW] = cnt_r;
        ctrl_s            = 32'd0;
        ctrl_s[15:0]      = hold_r;
        ctrl_s[16]        = enable_r;
    end

    // Response data and error for the access executing this cycle
    always_comb begin
        rdata_s = 32'd0;
        err_s   = 1'b0;
        if (access_s) begin
            case (sel_s)
                SEL_DATA: begin
                    if (data_we) begin
                        err_s = data_be[0] & full_s;
                    end else begin
                        rdata_s[PORT_W-1:0] = debug_r;
                    end
                end
                SEL_STATUS: begin
                    if (data_we) begin
                        rdata_s = 32'd0;
                    end else begin
                        rdata_s = status_s;
                    end
                end
                SEL_CTRL: begin
                    if (data_we) begin
                        rdata_s = 32'd0;
                    end else begin
                        rdata_s = ctrl_s;
                    end
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            rdata_s = 32'd0;
            err_s   = 1'b0;
        end
    end

    // Bus handshake: single-cycle grant pulse and registered response
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_r    <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            gnt_r    <= data_req & ~gnt_r;
            rvalid_r <= access_s;
            rdata_r  <= rdata_s;
            err_r    <= err_s;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_wdata[PORT_W-1:0];
        end
    end

    // FIFO pointers and occupancy; flush overrides any pop this cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (flush_s) begin
            rd_ptr_r <= wr_ptr_r;
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Control registers: byte-lane writes to CTRL, sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_r    <= 1'b0;
            hold_r   <= 16'd0;
            enable_r <= 1'b1;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
            if (ctrl_wr_s && data_be[0]) begin
                hold_r[7:0] <= data_wdata[7:0];
            end
            if (ctrl_wr_s && data_be[1]) begin
                hold_r[15:8] <= data_wdata[15:8];
            end
            if (ctrl_wr_s && data_be[2]) begin
                enable_r <= data_wdata[16];
            end
        end
    end

    // Drain engine: present each entry, then count down the hold interval
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            hcnt_r  <= 16'd0;
            debug_r <= {PORT_W{1'b0}};
            stb_r   <= 1'b0;
        end else begin
            stb_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        debug_r <= mem_r[rd_ptr_r];
                        stb_r   <= 1'b1;
                        hcnt_r  <= hold_r;
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (hcnt_r != 16'd0) begin
                        hcnt_r <= hcnt_r - 16'd1;
                    end else if (pop_s) begin
                        debug_r <= mem_r[rd_ptr_r];
                        stb_r   <= 1'b1;
                        hcnt_r  <= hold_r;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    hcnt_r  <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_trace_port.sv
`timescale 1ns/1ps
// Self-checking bench for debug_trace_port: a register-map vector table plus
// hand-written multi-cycle sequences for draining, overflow, flush and reset.
module tb_debug_trace_port;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic [7:0]  debugport;
    logic        debugport_stb;

    debug_trace_port #(.PORT_W(8), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_be       (data_be),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_gnt      (data_gnt),
        .data_rvalid   (data_rvalid),
        .data_rdata    (data_rdata),
        .data_err      (data_err),
        .debugport     (debugport),
        .debugport_stb (debugport_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Strobe monitor: cycle number and value of every debugport_stb pulse
    int         cyc = 0;
    int         stb_cyc[$];
    logic [7:0] stb_val[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (debugport_stb === 1'b1) begin
            stb_cyc.push_back(cyc);
            stb_val.push_back(debugport);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One bus access; returns read data, error and grant latency in cycles
    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
        data_req   = 1'b1;
        data_we    = we;
        data_be    = be;
        data_addr  = addr;
        data_wdata = wdata;
        @(posedge clk);
        #1;
        lat = 1;
        while (data_gnt !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("gnt_seen", {31'd0, data_gnt}, 32'd1);
        @(posedge clk);
        #1;
        data_req = 1'b0;
        check("rvalid_seen", {31'd0, data_rvalid}, 32'd1);
        check("gnt_not_back_to_back", {31'd0, data_gnt}, 32'd0);
        rdata = data_rdata;
        err   = data_err;
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bus(1'b1, addr, be, wdata, rd, er, lat);
        check({name, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        er;
        int          lat;
        bus(1'b0, addr, 4'hF, 32'h0, r, er, lat);
        check({name, "_rdata"}, r, exp);
        check({name, "_err"}, {31'd0, er}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t        tbl[20];
    logic [31:0] r;
    logic        e;
    int          lat;
    int          base;

    initial begin
        tbl[0]  = '{1'b0, 32'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0001, 1'b0, "status_after_reset"};
        tbl[1]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'h0001_0000, 1'b0, "ctrl_after_reset"};
        tbl[2]  = '{1'b1, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, "ctrl_clear_all"};
        tbl[3]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, "ctrl_cleared"};
        tbl[4]  = '{1'b1, 32'h0000_0008, 4'h1, 32'h0003_1234, 32'h0000_0000, 1'b0, "ctrl_wr_byte0"};
        tbl[5]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'h0000_0034, 1'b0, "ctrl_byte0_only"};
        tbl[6]  = '{1'b1, 32'h0000_0008, 4'h2, 32'h0000_5600, 32'h0000_0000, 1'b0, "ctrl_wr_byte1"};
        tbl[7]  = '{1'b0, 32'hFFFF_FF08, 4'hF, 32'h0000_0000, 32'h0000_5634, 1'b0, "ctrl_high_addr"};
        tbl[8]  = '{1'b1, 32'h0000_0000, 4'hE, 32'h0000_0077, 32'h0000_0000, 1'b0, "data_be0_clear"};
        tbl[9]  = '{1'b0, 32'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0001, 1'b0, "status_no_push"};
        tbl[10] = '{1'b1, 32'h0000_0000, 4'h1, 32'hFFFF_FF42, 32'h0000_0000, 1'b0, "data_push"};
        tbl[11] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0100, 1'b0, "status_count1"};
        tbl[12] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, "data_read_idle"};
        tbl[13] = '{1'b0, 32'h0000_000C, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, "unmapped_read"};
        tbl[14] = '{1'b1, 32'h0000_000C, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "unmapped_write"};
        tbl[15] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'h0000_5634, 1'b0, "ctrl_untouched"};
        tbl[16] = '{1'b1, 32'h0000_0008, 4'h4, 32'h0002_0000, 32'h0000_0000, 1'b0, "ctrl_flush"};
        tbl[17] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0001, 1'b0, "status_flushed"};
        tbl[18] = '{1'b1, 32'h0000_0004, 4'hF, 32'h0000_0004, 32'h0000_0000, 1'b0, "status_write"};
        tbl[19] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0001, 1'b0, "status_final"};

        // Reset values
        do_reset();
        check("rst_gnt",    {31'd0, data_gnt},      32'd0);
        check("rst_rvalid", {31'd0, data_rvalid},   32'd0);
        check("rst_err",    {31'd0, data_err},      32'd0);
        check("rst_rdata",  data_rdata,             32'd0);
        check("rst_debug",  {24'd0, debugport},     32'd0);
        check("rst_stb",    {31'd0, debugport_stb}, 32'd0);

        // Register map table
        for (int i = 0; i < 20; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, r, e, lat);
            check({tbl[i].name, "_rdata"}, r, tbl[i].exp_rdata);
            check({tbl[i].name, "_err"}, {31'd0, e}, {31'd0, tbl[i].exp_err});
        end

        // Single push drains onto the port with one strobe
        do_reset();
        base = stb_val.size();
        bus(1'b1, 32'h0, 4'h1, 32'h0000_00A5, r, e, lat);
        check("a5_gnt_latency", lat, 32'd1);
        check("a5_err", {31'd0, e}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("a5_debugport", {24'd0, debugport}, 32'h0000_00A5);
        check("a5_stb_count", stb_val.size() - base, 32'd1);
        if (stb_val.size() > base) check("a5_stb_value", {24'd0, stb_val[base]}, 32'h0000_00A5);
        rd("a5_status", 32'h4, 32'h0000_0001);
        rd("a5_data_read", 32'h0, 32'h0000_00A5);

        // hold=3: each entry shown for four cycles
        do_reset();
        wr("h3_ctrl", 32'h8, 4'h3, 32'h0000_0003, 1'b0);
        base = stb_val.size();
        wr("h3_push11", 32'h0, 4'h1, 32'h0000_0011, 1'b0);
        wr("h3_push22", 32'h0, 4'h1, 32'h0000_0022, 1'b0);
        rd("h3_status_busy", 32'h4, 32'h0000_0108);
        repeat (12) @(posedge clk);
        #1;
        check("h3_stb_count", stb_val.size() - base, 32'd2);
        if (stb_val.size() >= base + 2) begin
            check("h3_first",  {24'd0, stb_val[base]},     32'h0000_0011);
            check("h3_second", {24'd0, stb_val[base + 1]}, 32'h0000_0022);
            check("h3_spacing", stb_cyc[base + 1] - stb_cyc[base], 32'd4);
        end
        check("h3_debug_hold", {24'd0, debugport}, 32'h0000_0022);
        rd("h3_status_idle", 32'h4, 32'h0000_0001);

        // Overflow with drain disabled
        do_reset();
        wr("ov_disable", 32'h8, 4'h4, 32'h0000_0000, 1'b0);
        for (int i = 0; i <= DEPTH; i++) begin
            wr("ov_push", 32'h0, 4'h1, 32'h30 + i, (i == DEPTH));
        end
        rd("ov_status_full", 32'h4, 32'h0000_1006);
        wr("ov_be0_clear", 32'h0, 4'h2, 32'h0000_0099, 1'b0);
        rd("ov_status_sticky", 32'h4, 32'h0000_1006);
        wr("ov_clear", 32'h4, 4'h1, 32'h0000_0004, 1'b0);
        rd("ov_status_cleared", 32'h4, 32'h0000_1002);

        // Flush, and unmapped access afterwards
        do_reset();
        base = stb_val.size();
        wr("fl_disable", 32'h8, 4'h4, 32'h0000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr("fl_push", 32'h0, 4'h1, 32'h5 + i, 1'b0);
        end
        rd("fl_status_3", 32'h4, 32'h0000_0300);
        wr("fl_flush", 32'h8, 4'h4, 32'h0002_0000, 1'b0);
        rd("fl_status_empty", 32'h4, 32'h0000_0001);
        rd("fl_ctrl_flush_reads0", 32'h8, 32'h0000_0000);
        bus(1'b0, 32'hC, 4'hF, 32'h0, r, e, lat);
        check("fl_unmapped_rdata", r, 32'd0);
        check("fl_unmapped_err", {31'd0, e}, 32'd1);
        check("fl_no_stb", stb_val.size() - base, 32'd0);
        check("fl_debug", {24'd0, debugport}, 32'd0);

        // Reset during a hold=0 drain, with a request pending
        do_reset();
        wr("rs_disable", 32'h8, 4'h4, 32'h0000_0000, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            wr("rs_push", 32'h0, 4'h1, i, 1'b0);
        end
        base = stb_val.size();
        wr("rs_enable", 32'h8, 4'h4, 32'h0001_0000, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h4;
        @(posedge clk);
        #1;
        check("rs_gnt",    {31'd0, data_gnt},      32'd0);
        check("rs_rvalid", {31'd0, data_rvalid},   32'd0);
        check("rs_err",    {31'd0, data_err},      32'd0);
        check("rs_rdata",  data_rdata,             32'd0);
        check("rs_debug",  {24'd0, debugport},     32'd0);
        check("rs_stb",    {31'd0, debugport_stb}, 32'd0);
        check("rs_stb_before", stb_val.size() - base, 32'd2);
        @(posedge clk);
        #1;
        check("rs_gnt_held", {31'd0, data_gnt}, 32'd0);
        data_req = 1'b0;
        rst      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rs_no_more_stb", stb_val.size() - base, 32'd2);
        check("rs_debug_after", {24'd0, debugport}, 32'd0);
        rd("rs_status", 32'h4, 32'h0000_0001);
        rd("rs_ctrl", 32'h8, 32'h0001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_trace_port.md
DEBUG_TRACE_PORT -- requirements
Module: debug_trace_port

Interface
REQ-001 Parameter PORT_W, default 8, SHALL set the debug output width; legal range 8..32.
REQ-002 Parameter DEPTH, default 16, SHALL set the FIFO entry count; power of two, 2..128.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 data_req  input  1  bus request; addr/we/be/wdata stable until granted.
REQ-006 data_we  input  1  1 = write, 0 = read.
REQ-007 data_be  input  4  byte enables.
REQ-008 data_addr  input  32  byte address; only [3:2] decoded.
REQ-009 data_wdata  input  32  write data.
REQ-010 data_gnt  output  1  grant, registered.
REQ-011 data_rvalid  output  1  response valid, registered.
REQ-012 data_rdata  output  32  read data, valid with data_rvalid.
REQ-013 data_err  output  1  error response, valid with data_rvalid.
REQ-014 debugport  output  PORT_W  current trace value.
REQ-015 debugport_stb  output  1  one-cycle pulse marking a new debugport value.

Function
REQ-016 Grant: data_gnt SHALL be 1 the cycle after any cycle with data_req=1 and data_gnt=0; never asserted two consecutive cycles.
REQ-017 An access SHALL execute in the cycle data_req=1 and data_gnt=1; data_rvalid, data_rdata, data_err SHALL be registered from that cycle and asserted exactly one cycle later.
REQ-018 data_rdata SHALL be 0 and data_err 0 on every response except where stated below.
REQ-019 Map: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC unmapped.
REQ-020 DATA write with be[0]=1 SHALL push data_wdata[PORT_W-1:0] into the FIFO; be[0]=0 SHALL be a no-op with no error.
REQ-021 DATA write when FIFO full (count before the cycle = DEPTH) SHALL drop data, set STATUS.ovf, respond data_err=1; a same-cycle pop SHALL NOT make room.
REQ-022 DATA read SHALL return debugport zero-extended.
REQ-023 STATUS read: [0] empty, [1] full, [2] ovf (sticky), [3] busy (state ACTIVE), [15:8] count (zero-extended), rest 0.
REQ-024 STATUS write with wdata[2]=1 and be[0]=1 SHALL clear ovf; other bits ignored.
REQ-025 CTRL: [15:0] hold, [16] enable, [17] flush (write-only, reads 0); writes honour be per byte.
REQ-026 Flush SHALL empty the FIFO that cycle (count=0, pointers equal); flush wins over a same-cycle pop; debugport unchanged.
REQ-027 Access to 0xC SHALL respond data_err=1, rdata 0, no state change.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-029 Drain FSM states IDLE, ACTIVE; "pop" = FIFO not empty, enable=1, no flush this cycle.
REQ-030 IDLE: on pop SHALL load head into debugport, pulse debugport_stb next cycle, load hcnt=hold, enter ACTIVE; else stay IDLE.
REQ-031 ACTIVE: hcnt!=0 SHALL decrement; hcnt=0 with pop SHALL load next entry, pulse stb, reload hcnt=hold (stay ACTIVE); hcnt=0 without pop SHALL return to IDLE.
REQ-032 Each entry SHALL thus be shown for hold+1 cycles minimum; hold=0 gives one entry per cycle back-to-back.
REQ-033 Clearing enable SHALL block new pops only; the current hold interval completes.
REQ-034 debugport SHALL hold its last value indefinitely when the FIFO is empty.

Reset
REQ-035 When rst=0 on a clock edge: data_gnt, data_rvalid, data_err, debugport_stb=0; data_rdata=0; debugport=0; FIFO empty; ovf=0; hold=0; enable=1; state IDLE; hcnt=0.
REQ-036 Reset mid-transfer SHALL abandon the access with no response; mid-hold SHALL abort the interval.

Verification
REQ-037 Reset, write 0x0 wdata=0xA5 be=0x1 -> gnt 1 cycle after req, rvalid next, err=0; debugport=0xA5 with one stb pulse, STATUS reads 0x00000001.
REQ-038 hold=3, push 0x11,0x22 -> debugport 0x11 for 4 cycles then 0x22, exactly two stb pulses, busy then idle.
REQ-039 enable=0, push DEPTH+1 words -> last write err=1, STATUS full=1 ovf=1 count=DEPTH; write STATUS 0x4 -> ovf=0.
REQ-040 enable=0, push 3, write CTRL flush -> STATUS count=0 empty=1, no stb; read 0xC -> err=1 rdata=0.
REQ-041 hold=0, 4 queued, assert rst=0 during drain -> all outputs/state per REQ-035 next cycle, no further stb.
